// File: rtl/ahblite_sys.sv
// ahblite_sys: fixed-sequence AHB-Lite master copying switches to LED and VGA colour slaves, with 640x480 VGA timing.
module ahblite_sys #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS = 640, parameter int H_FP = 16, parameter int H_SYNC = 96, parameter int H_BP = 48,
  parameter int V_VIS = 480, parameter int V_FP = 10, parameter int V_SYNC = 2,  parameter int V_BP = 33
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] SW,
  output logic [7:0] LED,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic [2:0] VGARED,
  output logic [2:0] VGAGREEN,
  output logic [1:0] VGABLUE
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_L = HW'(H_VIS);
  localparam logic [HW-1:0] HS_ON = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_L = VW'(V_VIS);
  localparam logic [VW-1:0] VS_ON = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10;
  localparam logic [1:0] S_DEF = 2'd0, S_SW = 2'd1, S_LED = 2'd2, S_VGA = 2'd3;

  typedef enum logic [2:0] {RD_SW_A, RD_SW_D, WR_LED_A, WR_LED_D, WR_VGA_A, WR_VGA_D} state_t;

  state_t      r_state;
  logic [1:0]  r_htrans;
  logic        r_hwrite;
  logic [31:0] r_haddr;
  logic [7:0]  r_data;
  logic [7:0]  r_sw1, r_sw2, r_led, r_colour, r_rgb;
  logic [1:0]  r_dsel;
  logic        r_dwr;
  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic        w_hready;
  logic [7:0]  w_hsel_hi;
  logic [1:0]  w_asel;
  logic [31:0] w_hwdata, w_hrdata;
  logic        w_div_end, w_h_end, w_v_end;

  assign w_hready = 1'b1;
  assign w_hwdata = {24'b0, r_data};
  assign w_hsel_hi = 8'(r_haddr >> 24);
  assign w_asel = w_hsel_hi == 8'h50 ? S_SW : w_hsel_hi == 8'h51 ? S_LED :
                  w_hsel_hi == 8'h52 ? S_VGA : S_DEF;
  assign w_hrdata = {24'b0, r_dsel == S_SW ? r_sw2 : r_dsel == S_LED ? r_led :
                            r_dsel == S_VGA ? r_colour : 8'h00};

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_state <= RD_SW_A;
      r_htrans <= NONSEQ;
      r_hwrite <= 1'b0;
      r_haddr <= 32'h5000_0000;
      r_data <= 8'h00;
    end else if (w_hready) begin
      case (r_state)
        RD_SW_A:  begin r_state <= RD_SW_D;  r_htrans <= IDLE; end
        RD_SW_D:  begin r_state <= WR_LED_A; r_htrans <= NONSEQ; r_hwrite <= 1'b1; r_haddr <= 32'h5100_0000; r_data <= 8'(w_hrdata); end
        WR_LED_A: begin r_state <= WR_LED_D; r_htrans <= IDLE; end
        WR_LED_D: begin r_state <= WR_VGA_A; r_htrans <= NONSEQ; r_haddr <= 32'h5200_0000; end
        WR_VGA_A: begin r_state <= WR_VGA_D; r_htrans <= IDLE; end
        default:  begin r_state <= RD_SW_A;  r_htrans <= NONSEQ; r_hwrite <= 1'b0; r_haddr <= 32'h5000_0000; end
      endcase
    end

  // Address phase is latched here; slave registers update at the end of the data phase.
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_sw1 <= 8'h00;
      r_sw2 <= 8'h00;
      r_dsel <= S_DEF;
      r_dwr <= 1'b0;
      r_led <= 8'h00;
      r_colour <= 8'h00;
    end else begin
      r_sw1 <= SW;
      r_sw2 <= r_sw1;
      if (w_hready) begin
        r_dsel <= r_htrans[1] ? w_asel : S_DEF;
        r_dwr <= r_htrans[1] & r_hwrite;
      end
      if (r_dwr && r_dsel == S_LED) r_led <= 8'(w_hwdata);
      if (r_dwr && r_dsel == S_VGA) r_colour <= 8'(w_hwdata);
    end

  assign w_div_end = r_div == DIV_LAST;
  assign w_h_end = r_h == H_LAST;
  assign w_v_end = r_v == V_LAST;

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_div <= '0;
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_div <= w_div_end ? '0 : r_div + 1'b1;
      if (w_div_end) r_h <= w_h_end ? '0 : r_h + 1'b1;
      if (w_div_end && w_h_end) r_v <= w_v_end ? '0 : r_v + 1'b1;
    end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      HSYNC <= 1'b1;
      VSYNC <= 1'b1;
      r_rgb <= 8'h00;
    end else begin
      HSYNC <= !(r_h >= HS_ON && r_h < HS_OFF);
      VSYNC <= !(r_v >= VS_ON && r_v < VS_OFF);
      r_rgb <= (r_h < H_VIS_L && r_v < V_VIS_L) ? r_colour : 8'h00;
    end

  assign LED = r_led;
  assign {VGARED, VGAGREEN, VGABLUE} = r_rgb;
endmodule

// File: tb/tb_ahblite_sys.sv
// tb_ahblite_sys: table vectors, random switch traffic and reset corner cases checked against a cycle model.
module tb_ahblite_sys;
  localparam int CD = 4, HT = 800, VV = 4, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] led;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } vec_t;

  logic       CLK = 1'b0, RESET = 1'b1;
  logic [7:0] SW = 8'h3A;
  logic [7:0] LED;
  logic       HSYNC, VSYNC;
  logic [2:0] VGARED, VGAGREEN;
  logic [1:0] VGABLUE;

  int n_cmp = 0, n_bad = 0, k = 0;
  logic [7:0] led_exp = 8'h00, col_exp = 8'h00, samp = 8'h00;
  vec_t tbl [4];

  ahblite_sys #(.CLK_DIV(CD), .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .CLK(CLK), .RESET(RESET), .SW(SW), .LED(LED), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .VGARED(VGARED), .VGAGREEN(VGAGREEN), .VGABLUE(VGABLUE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (edge %0d): got %h expected %h", name, k, act, exp);
    end
  endtask

  function automatic bit visible(input int kk);
    int p = (kk - 1) / CD;
    return (p % HT) < 640 && ((p / HT) % VT) < VV;
  endfunction

  // Output at edge kk reflects the pixel reached after kk-1 edges and the colour held before edge kk.
  function automatic logic [9:0] exp_vid(input int kk, input logic [7:0] col);
    int p = (kk - 1) / CD;
    int h = p % HT;
    int v = (p / HT) % VT;
    logic hs = !(h >= 656 && h < 752);
    logic vs = !(v >= VV + VF && v < VV + VF + VS);
    return {hs, vs, visible(kk) ? col : 8'h00};
  endfunction

  // The master loop samples the synchronised switches once every 6 edges; LED follows 4 edges later, colour 6.
  task automatic step();
    logic [9:0] ve;
    @(posedge CLK);
    k++;
    #1;
    ve = exp_vid(k, col_exp);
    if (k % 6 == 0) begin
      col_exp = samp;
      samp = SW;
    end
    if (k % 6 == 4) led_exp = samp;
    chk("video", {HSYNC, VSYNC, VGARED, VGAGREEN, VGABLUE}, ve);
    chk("led", LED, led_exp);
  endtask

  task automatic model_reset();
    k = 0;
    led_exp = 8'h00;
    col_exp = 8'h00;
    samp = 8'h00;
  endtask

  initial begin
    int w, fall, vs_low;
    logic [7:0] any;
    tbl[0] = '{8'h3A, 8'h3A, 3'b001, 3'b110, 2'b10};
    tbl[1] = '{8'hC5, 8'hC5, 3'd6, 3'd1, 2'd1};
    tbl[2] = '{8'hFF, 8'hFF, 3'd7, 3'd7, 2'd3};
    tbl[3] = '{8'h81, 8'h81, 3'd4, 3'd0, 2'd1};

    #17;
    chk("reset_led", LED, 8'h00);
    chk("reset_hsync", HSYNC, 1'b1);
    chk("reset_vsync", VSYNC, 1'b1);
    chk("reset_rgb", {VGARED, VGAGREEN, VGABLUE}, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();

    for (int i = 0; i < 4; i++) begin
      SW = tbl[i].sw;
      repeat (12) step();
      chk("vec_led", LED, tbl[i].led);
      w = 0;
      step();
      while (!visible(k) && w < 30000) begin
        step();
        w++;
      end
      if (w >= 30000) chk("vec_visible_timeout", w, 0);
      chk("vec_red", VGARED, tbl[i].r);
      chk("vec_green", VGAGREEN, tbl[i].g);
      chk("vec_blue", VGABLUE, tbl[i].b);
    end

    repeat (5000) begin
      if ($urandom_range(0, 99) == 0) SW = 8'($urandom);
      step();
    end

    SW = 8'h00;
    repeat (20) step();
    any = 8'h00;
    vs_low = 0;
    repeat (VT * HT * CD) begin
      step();
      any |= {VGARED, VGAGREEN, VGABLUE};
      vs_low += int'(!VSYNC);
    end
    chk("zero_frame_rgb", any, 8'h00);
    chk("vsync_low_cycles", vs_low, VS * HT * CD);

    SW = 8'h3A;
    repeat (30) step();
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    chk("midreset_led", LED, 8'h00);
    chk("midreset_rgb", {VGARED, VGAGREEN, VGABLUE}, 8'h00);
    chk("midreset_hsync", HSYNC, 1'b1);
    chk("midreset_vsync", VSYNC, 1'b1);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    fall = -1;
    repeat (3000) begin
      step();
      if (fall < 0 && !HSYNC) fall = k;
    end
    chk("hsync_fall_after_release", fall - 1, 2624);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
